// File: rtl/mem.sv
// Single-port 256x16 data memory: synchronous write, registered read,
// write-first on a simultaneous read/write, async active-high clear.
module mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Read-path mux: a same-cycle write forwards its data instead of the old word
  always_comb begin
    w_rd_data = {DATA_WIDTH{1'b0}};
    if (MemWrite) begin
      w_rd_data = data_in;
    end else begin
      w_rd_data = r_mem[addr_in];
    end
  end

  // Storage array: whole array cleared by reset, one word written per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '{default: {DATA_WIDTH{1'b0}}};
    end else if (MemWrite) begin
      r_mem[addr_in] <= data_in;
    end
  end

  // Read register: loads only on MemRead, otherwise holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= {DATA_WIDTH{1'b0}};
    end else if (MemRead) begin
      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_mem.sv
// Directed + randomised bench for mem with a scoreboard queue and a
// small reference model of the array and read register.
module tb_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [7:0]  addr_in = 8'h00;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;

  int checks = 0;
  int fails  = 0;

  logic [15:0] model_mem [256];
  logic [15:0] model_out;
  logic [15:0] exp_q [$];

  mem dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    model_out = 16'h0000;
  endtask

  // Drive one access at the falling edge, predict, then compare after the rising edge.
  task automatic step(input string tag, input logic we, input logic re,
                      input logic [7:0] a, input logic [15:0] d);
    logic [15:0] exp;
    @(negedge clk);
    MemWrite = we;
    MemRead  = re;
    addr_in  = a;
    data_in  = d;
    if (re) model_out = we ? d : model_mem[a];
    if (we) model_mem[a] = d;
    exp_q.push_back(model_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 16'hDEAD, 16'h0000);
    end else begin
      exp = exp_q.pop_front();
      check(tag, data_out, exp);
    end
  endtask

  initial begin
    model_clear();
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", data_out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    step("rd_rst_00", 1'b0, 1'b1, 8'h00, 16'h0000);
    check("rd_rst_00_k", data_out, 16'h0000);
    step("rd_rst_06", 1'b0, 1'b1, 8'h06, 16'h0000);
    step("rd_rst_ff", 1'b0, 1'b1, 8'hFF, 16'h0000);
    check("rd_rst_ff_k", data_out, 16'h0000);

    step("wr_10_noread", 1'b1, 1'b0, 8'h10, 16'h8888);
    check("wr_10_hold_k", data_out, 16'h0000);
    step("rd_10", 1'b0, 1'b1, 8'h10, 16'h0000);
    check("rd_10_k", data_out, 16'h8888);

    step("rd_06_din", 1'b0, 1'b1, 8'h06, 16'h1111);
    check("rd_06_din_k", data_out, 16'h0000);
    step("rd_06_again", 1'b0, 1'b1, 8'h06, 16'h0000);

    step("rw_08", 1'b1, 1'b1, 8'h08, 16'hADAD);
    check("rw_08_k", data_out, 16'hADAD);
    step("rd_08", 1'b0, 1'b1, 8'h08, 16'h0000);
    check("rd_08_k", data_out, 16'hADAD);

    for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 8'h10, 16'h5555);
    check("hold_k", data_out, 16'hADAD);
    step("hold_wr", 1'b1, 1'b0, 8'h30, 16'h1234);
    check("hold_wr_k", data_out, 16'hADAD);
    step("rd_30", 1'b0, 1'b1, 8'h30, 16'h0000);
    step("rd_ff_bound", 1'b1, 1'b0, 8'hFF, 16'hF00F);
    step("rd_ff", 1'b0, 1'b1, 8'hFF, 16'h0000);
    check("rd_ff_k", data_out, 16'hF00F);

    // Async reset between edges, with a write pending across the reset edge.
    @(negedge clk);
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    addr_in  = 8'h20;
    data_in  = 16'hBEEF;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_out", data_out, 16'h0000);
    model_clear();
    @(posedge clk);
    #1;
    check("rst_mid_held", data_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    MemWrite = 1'b0;

    step("post_rst_08", 1'b0, 1'b1, 8'h08, 16'h0000);
    step("post_rst_10", 1'b0, 1'b1, 8'h10, 16'h0000);
    check("post_rst_10_k", data_out, 16'h0000);
    step("post_rst_20", 1'b0, 1'b1, 8'h20, 16'h0000);
    step("post_rst_ff", 1'b0, 1'b1, 8'hFF, 16'h0000);

    for (int i = 0; i < 200; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 16'($urandom));
    end
    for (int i = 0; i < 16; i++) step("sweep", 1'b0, 1'b1, 8'(i), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Single-port, word-addressed synchronous data memory: 256 words x 16 bits.
- Used as the datapath's data memory, driven by the control unit's MemRead/MemWrite strobes.
- Synchronous write and registered read, both on the rising clock edge.
- Asynchronous reset clears the whole array and the read register.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 256, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- reset  input  1  asynchronous, active-high; clears the memory array and data_out.
- MemWrite  input  1  write enable, sampled at the rising edge.
- MemRead  input  1  read enable, sampled at the rising edge.
- addr_in  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset asserted:
  - All DEPTH words become 16'h0000 immediately, without waiting for a clock edge.
  - data_out becomes 16'h0000 immediately.
  - Both stay cleared while reset is high; rising edges during reset perform no read or write.
- Write: at a rising edge with reset=0 and MemWrite=1, mem[addr_in] <= data_in. No other location changes.
- Read: at a rising edge with reset=0 and MemRead=1, data_out <= mem[addr_in]. Latency is 1 cycle from the sampled address.
- MemRead=0: data_out holds its previous value, whatever MemWrite does.
- MemRead=1 and MemWrite=1 in the same cycle: write-first.
  - mem[addr_in] <= data_in.
  - data_out <= data_in (the new data, not the old contents).
- Both enables 0: no state change.
- Addresses: full 8-bit range 0x00-0xFF is valid. No wrap-around or out-of-range case exists when DEPTH = 2**ADDR_WIDTH.
- Enables or address at X/Z while reset=0: no defined behaviour is required, and the bench must not rely on any.
- Reset mid-operation: a write coincident with reset assertion is discarded, and the location reads 0000 afterwards.
- No other outputs, flags or handshake. Every access completes in one cycle.

Test Plan:
- Reset, then read back: hold reset=1 for one cycle, release, then read 0x00, 0x06 and 0xFF with MemRead=1, MemWrite=0 -> data_out = 0000 one edge after each address.
- Write then read: MemWrite=1, MemRead=0, addr 0x10, data 8888, one edge -> data_out unchanged (0000). Then MemRead=1, addr 0x10 -> data_out = 8888 after the next edge.
- Read of unwritten location after a write elsewhere: addr 0x06, MemRead=1, data_in=1111, MemWrite=0 -> data_out = 0000 and mem[0x06] stays 0000.
- Simultaneous read/write: MemRead=1, MemWrite=1, addr 0x08, data ADAD -> data_out = ADAD at that same edge. A following read of 0x08 with MemWrite=0 -> ADAD.
- Hold behaviour: after data_out = ADAD, set MemRead=0 and change addr to 0x10 for several cycles -> data_out stays ADAD.
- Async reset mid-run: after the writes above, assert reset between clock edges -> data_out = 0000 immediately. After release, reads of 0x08 and 0x10 return 0000.
